// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, datapath
// select encodings, and the FSM state enum. When MC_BNE_EN is defined the
// bne instruction and its execute state are part of the machine.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MC_BNE_EN
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
`else
    S_JEX     = 4'd11
`endif
  } mc_state_e;

  // True for every opcode the controller knows how to execute.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute,
// plus a retired-instruction counter. Optional macro MC_BNE_EN adds bne.
// state_dbg exposes the current FSM state for observation.
module mc_controller
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [1:0]  aluop,
  output logic        pcen,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [3:0]  state_dbg
);

  mc_state_e   state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        retire;
  logic        pcwrite;
  logic        branch_take;

  // State and retire counter; reset wins over any in-progress access.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
`ifdef MC_BNE_EN
      S_BNEEX:   state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; fetch strobes are held off while reset is asserted.
  always_comb begin
    iord        = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REGB;
    pcsrc       = PCSRC_ALU;
    aluop       = ALUOP_ADD;
    illegal     = 1'b0;
    pcwrite     = 1'b0;
    branch_take = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready & reset_n;
        pcwrite = mem_ready & reset_n;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH2;
        illegal = ~is_legal_op(op);
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        branch_take = zero;
      end
`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcsrc       = PCSRC_ALUOUT;
        branch_take = ~zero;
      end
`endif
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = PCSRC_JUMP;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
    pcen = pcwrite | branch_take;
  end

  // An instruction retires on the cycle it leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      S_MEMWB, S_RTYPEWB, S_ADDIWB, S_BEQEX, S_JEX: retire = 1'b1;
`ifdef MC_BNE_EN
      S_BNEEX: retire = 1'b1;
`endif
      S_MEMWR: retire = mem_ready;
      default: retire = 1'b0;
    endcase
    instret_d = instret_q + {31'd0, retire};
  end

  assign instret   = instret_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboarded bench for mc_controller: each driven cycle pushes the
// hand-computed expected state/controls/instret; a negedge monitor pops and
// compares. Honors MC_BNE_EN for the bne sequence.
module tb_mc_controller;
  import mips_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]  alusrcb, pcsrc, aluop;
  logic        pcen, illegal;
  logic [31:0] instret;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected entry: {state[3:0], ctl[14:0], instret[31:0]}
  logic [50:0] exp_q[$];

  // ctl bit order: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,
  //                alusrcb[2],pcsrc[2],aluop[2],pcen,illegal
  localparam logic [14:0] C_FETCH   = {7'b0010000, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [14:0] C_FETCH_W = {7'b0000000, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_DECODE  = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_DEC_ILL = {7'b0000000, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
  localparam logic [14:0] C_MEMADR  = {7'b0000001, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_MEMRD   = {7'b1000000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_MEMWB   = {7'b0000110, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_MEMWR   = {7'b1100000, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_RTYPEEX = {7'b0000001, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [14:0] C_RTYPEWB = {7'b0001010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_BR_T    = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
  localparam logic [14:0] C_BR_N    = {7'b0000001, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0};
  localparam logic [14:0] C_ADDIWB  = {7'b0000010, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [14:0] C_JEX     = {7'b0000000, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0};

`ifdef MC_BNE_EN
  localparam logic [31:0] N_AFTER_BNE = 32'd8;
`else
  localparam logic [31:0] N_AFTER_BNE = 32'd7;
`endif

  mc_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .zero      (zero),
    .mem_ready (mem_ready),
    .iord      (iord),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .pcen      (pcen),
    .illegal   (illegal),
    .instret   (instret),
    .state_dbg (state_dbg)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drive one cycle of inputs and record what the DUT must show in it.
  task automatic step(input logic rn, input logic [5:0] o, input logic z,
                      input logic mr, input mc_state_e st,
                      input logic [14:0] ctl, input logic [31:0] ir);
    @(posedge clk);
    #1;
    reset_n   = rn;
    op        = o;
    zero      = z;
    mem_ready = mr;
    exp_q.push_back({st, ctl, ir});
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [50:0] e;
      logic [14:0] act_ctl;
      e = exp_q.pop_front();
      act_ctl = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, aluop, pcen, illegal};
      checks++;
      if (state_dbg !== e[50:47]) begin
        errors++;
        $display("FAIL state cyc=%0d got=%0d want=%0d", cyc, state_dbg, e[50:47]);
      end
      checks++;
      if (act_ctl !== e[46:32]) begin
        errors++;
        $display("FAIL ctl cyc=%0d got=%b want=%b", cyc, act_ctl, e[46:32]);
      end
      checks++;
      if (instret !== e[31:0]) begin
        errors++;
        $display("FAIL instret cyc=%0d got=%0d want=%0d", cyc, instret, e[31:0]);
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    op        = OP_RTYPE;
    zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset: FETCH with fetch strobes suppressed even though mem_ready=1
    step(1'b0, OP_RTYPE, 1'b0, 1'b1, S_FETCH, C_FETCH_W, 32'd0);
    step(1'b0, OP_RTYPE, 1'b0, 1'b1, S_FETCH, C_FETCH_W, 32'd0);

    // lw, no stalls: 5 cycles
    step(1'b1, OP_LW, 1'b0, 1'b1, S_FETCH,  C_FETCH,  32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_DECODE, C_DECODE, 32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_MEMADR, C_MEMADR, 32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_MEMRD,  C_MEMRD,  32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_MEMWB,  C_MEMWB,  32'd0);

    // sw: one fetch stall, three write stalls -> memwrite for 4 cycles
    step(1'b1, OP_SW, 1'b0, 1'b0, S_FETCH,  C_FETCH_W, 32'd1);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_FETCH,  C_FETCH,   32'd1);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_DECODE, C_DECODE,  32'd1);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_MEMADR, C_MEMADR,  32'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, OP_SW, 1'b0, 1'b0, S_MEMWR, C_MEMWR, 32'd1);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_MEMWR,  C_MEMWR,   32'd1);

    // R-type
    step(1'b1, OP_RTYPE, 1'b0, 1'b1, S_FETCH,   C_FETCH,   32'd2);
    step(1'b1, OP_RTYPE, 1'b0, 1'b1, S_DECODE,  C_DECODE,  32'd2);
    step(1'b1, OP_RTYPE, 1'b0, 1'b1, S_RTYPEEX, C_RTYPEEX, 32'd2);
    step(1'b1, OP_RTYPE, 1'b0, 1'b1, S_RTYPEWB, C_RTYPEWB, 32'd2);

    // beq taken, then not taken
    step(1'b1, OP_BEQ, 1'b1, 1'b1, S_FETCH,  C_FETCH,  32'd3);
    step(1'b1, OP_BEQ, 1'b1, 1'b1, S_DECODE, C_DECODE, 32'd3);
    step(1'b1, OP_BEQ, 1'b1, 1'b1, S_BEQEX,  C_BR_T,   32'd3);
    step(1'b1, OP_BEQ, 1'b0, 1'b1, S_FETCH,  C_FETCH,  32'd4);
    step(1'b1, OP_BEQ, 1'b0, 1'b1, S_DECODE, C_DECODE, 32'd4);
    step(1'b1, OP_BEQ, 1'b0, 1'b1, S_BEQEX,  C_BR_N,   32'd4);

    // addi
    step(1'b1, OP_ADDI, 1'b0, 1'b1, S_FETCH,  C_FETCH,  32'd5);
    step(1'b1, OP_ADDI, 1'b0, 1'b1, S_DECODE, C_DECODE, 32'd5);
    step(1'b1, OP_ADDI, 1'b0, 1'b1, S_ADDIEX, C_MEMADR, 32'd5);
    step(1'b1, OP_ADDI, 1'b0, 1'b1, S_ADDIWB, C_ADDIWB, 32'd5);

    // j
    step(1'b1, OP_J, 1'b0, 1'b1, S_FETCH,  C_FETCH,  32'd6);
    step(1'b1, OP_J, 1'b0, 1'b1, S_DECODE, C_DECODE, 32'd6);
    step(1'b1, OP_J, 1'b0, 1'b1, S_JEX,    C_JEX,    32'd6);

    // Unsupported opcode: one illegal DECODE cycle, not retired
    step(1'b1, 6'b111111, 1'b0, 1'b1, S_FETCH,  C_FETCH,   32'd7);
    step(1'b1, 6'b111111, 1'b0, 1'b1, S_DECODE, C_DEC_ILL, 32'd7);

    // bne with zero=0
    step(1'b1, OP_BNE, 1'b0, 1'b1, S_FETCH, C_FETCH, 32'd7);
`ifdef MC_BNE_EN
    step(1'b1, OP_BNE, 1'b0, 1'b1, S_DECODE, C_DECODE, 32'd7);
    step(1'b1, OP_BNE, 1'b0, 1'b1, S_BNEEX,  C_BR_T,   32'd7);
`else
    step(1'b1, OP_BNE, 1'b0, 1'b1, S_DECODE, C_DEC_ILL, 32'd7);
`endif

    // sw interrupted by reset while stalled in MEMWR
    step(1'b1, OP_SW, 1'b0, 1'b1, S_FETCH,  C_FETCH,  N_AFTER_BNE);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_DECODE, C_DECODE, N_AFTER_BNE);
    step(1'b1, OP_SW, 1'b0, 1'b1, S_MEMADR, C_MEMADR, N_AFTER_BNE);
    step(1'b0, OP_SW, 1'b0, 1'b0, S_MEMWR,  C_MEMWR,  N_AFTER_BNE);
    step(1'b1, OP_SW, 1'b0, 1'b0, S_FETCH,  C_FETCH_W, 32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_FETCH,  C_FETCH,   32'd0);
    step(1'b1, OP_LW, 1'b0, 1'b1, S_DECODE, C_DECODE,  32'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock.
REQ-002 reset_n  input  1  synchronous, active-low reset; sampled on rising clk only.
REQ-003 op  input  6  instruction opcode from instruction register.
REQ-004 zero  input  1  ALU zero flag.
REQ-005 mem_ready  input  1  memory access completes this cycle.
REQ-006 iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca  output  1 each  datapath controls.
REQ-007 alusrcb  output  2  00 regB, 01 const 4, 10 signimm, 11 signimm<<2.
REQ-008 pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 aluop  output  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded.
REQ-010 pcen  output  1  pcwrite | (branch-taken).
REQ-011 illegal  output  1  unsupported opcode seen in DECODE.
REQ-012 instret  output  32  retired-instruction count.

Function
REQ-013 Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, ADDIEX, ADDIWB, JEX (+BNEEX, see REQ-030).
REQ-014 All outputs not listed for a state SHALL be 0.
REQ-015 FETCH: alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready; stay while mem_ready=0, else DECODE.
REQ-016 DECODE: alusrcb=11, aluop=00; next by op: 100011/101011 MEMADR, 000000 RTYPEEX, 000100 BEQEX, 001000 ADDIEX, 000010 JEX, other FETCH with illegal=1 this cycle.
REQ-017 MEMADR: alusrca=1, alusrcb=10, aluop=00; next MEMRD if op=100011, else MEMWR.
REQ-018 MEMRD: iord=1; stay while mem_ready=0, else MEMWB.
REQ-019 MEMWB: memtoreg=1, regwrite=1; next FETCH.
REQ-020 MEMWR: iord=1, memwrite=1; stay while mem_ready=0, else FETCH.
REQ-021 RTYPEEX: alusrca=1, alusrcb=00, aluop=10; next RTYPEWB. RTYPEWB: regdst=1, regwrite=1; next FETCH.
REQ-022 BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero; next FETCH.
REQ-023 ADDIEX: alusrca=1, alusrcb=10, aluop=00; next ADDIWB. ADDIWB: regwrite=1; next FETCH.
REQ-024 JEX: pcsrc=10, pcen=1; next FETCH.
REQ-025 pcen SHALL equal pcwrite except in branch-execute states.
REQ-026 Minimum latency (mem_ready=1): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each mem_ready=0 cycle adds one.
REQ-027 instret SHALL increment by 1, wrapping modulo 2^32, on each cycle leaving MEMWB, RTYPEWB, ADDIWB, BEQEX, JEX, or MEMWR with mem_ready=1; illegal opcodes not counted.

Reset
REQ-028 reset_n=0 at a clk edge SHALL force state FETCH and instret 0, overriding any in-progress access; memwrite/regwrite SHALL be 0 in the cycle after reset regardless of prior state.
REQ-029 During reset assertion outputs SHALL follow the current-state decode; while in FETCH under reset, irwrite/pcwrite SHALL be 0.

Configuration
REQ-030 Macro MC_BNE_EN defined: op 000101 in DECODE goes to BNEEX (alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=~zero, next FETCH, counted retired); undefined: 000101 is illegal, no BNEEX state exists.

Structure
REQ-031 Package mips_pkg SHALL hold opcode constants, aluop/alusrcb/pcsrc encodings, and the state enum typedef.
REQ-032 Single module; no sub-module; state register + next-state logic + output decode + instret counter.

Verification
REQ-033 lw (op=100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; regwrite=1 only in MEMWB; instret +1.
REQ-034 sw with mem_ready held 0 for 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; instret +1.
REQ-035 beq with zero=1 -> pcen=1, pcsrc=01 in BEQEX; zero=0 -> pcen=0; both retire.
REQ-036 op=111111 -> illegal=1 for one DECODE cycle, back to FETCH, instret unchanged.
REQ-037 reset_n=0 during MEMWR -> next cycle FETCH, memwrite=0, instret=0.
REQ-038 MC_BNE_EN on: bne with zero=0 -> pcen=1; off: bne -> illegal=1.
